// File: rtl/muldiv_sequencer_if.sv
// EX-stage request / HI-LO result bus of the multiply/divide sequencer.
// The pipeline drives the master side and the sequencer implements the slave side.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic [5:0]      func;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            flush;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mf_data;
    logic            busy;
    logic            stall;
    logic            done;

    modport master (output valid, func, rs_data, rt_data, flush,
                    input  hi, lo, mf_data, busy, stall, done);
    modport slave  (input  valid, func, rs_data, rt_data, flush,
                    output hi, lo, mf_data, busy, stall, done);
endinterface

// File: rtl/muldiv_sequencer.sv
// MIPS HI/LO sequencer: iterative shift-add multiply and restoring divide,
// MTHI/MTLO/MFHI/MFLO access, and a stall to the hazard unit while busy.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_P  = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ITER_C = CNT_W'(XLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    function automatic logic is_start(input logic [5:0] f);
        is_start = (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic is_hilo(input logic [5:0] f);
        is_hilo = is_start(f) || (f == F_MFHI) || (f == F_MFLO) ||
                  (f == F_MTHI) || (f == F_MTLO);
    endfunction

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        neg_x = ~v + ONE_X;
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        mag = (sgn && v[XLEN-1]) ? neg_x(v) : v;
    endfunction

    state_t           state_r;
    logic [XLEN-1:0]  hi_r, lo_r;
    logic [XLEN-1:0]  opa_r;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]  acc_r;      // upper product half or partial remainder
    logic [XLEN-1:0]  shr_r;      // multiplier/lower product or dividend/quotient
    logic [XLEN-1:0]  rs_raw_r;
    logic [CNT_W-1:0] cnt_r;
    logic             is_div_r, neg_res_r, neg_rem_r, div0_r;
    logic             busy_r, done_r;

    logic             sgn_op_s, div_op_s;
    logic [XLEN:0]    mul_sum_s, div_shift_s;
    logic             div_ge_s;
    logic [XLEN-1:0]  acc_next_s, shr_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]  hi_res_s, lo_res_s, mf_s;

    assign sgn_op_s = ~bus.func[0];
    assign div_op_s = bus.func[1];

    // One shift-add or restoring-divide step from the current datapath registers
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (shr_r[0] ? {1'b0, opa_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r, shr_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opa_r});
        if (is_div_r) begin
            acc_next_s = div_ge_s ? XLEN'(div_shift_s - {1'b0, opa_r}) : div_shift_s[XLEN-1:0];
            shr_next_s = {shr_r[XLEN-2:0], div_ge_s};
        end else begin
            acc_next_s = mul_sum_s[XLEN:1];
            shr_next_s = {mul_sum_s[0], shr_r[XLEN-1:1]};
        end
    end

    // Sign fixup and divide-by-zero override of the final HI/LO values
    always_comb begin
        prod_s   = {acc_r, shr_r};
        hi_res_s = acc_r;
        lo_res_s = shr_r;
        if (div0_r) begin
            hi_res_s = rs_raw_r;
            lo_res_s = {XLEN{1'b1}};
        end else if (is_div_r) begin
            lo_res_s = neg_res_r ? neg_x(shr_r) : shr_r;
            hi_res_s = neg_rem_r ? neg_x(acc_r) : acc_r;
        end else begin
            prod_s   = neg_res_r ? (~{acc_r, shr_r} + ONE_P) : {acc_r, shr_r};
            hi_res_s = prod_s[2*XLEN-1:XLEN];
            lo_res_s = prod_s[XLEN-1:0];
        end
    end

    // MFHI/MFLO read port straight off the architectural registers
    always_comb begin
        mf_s = {XLEN{1'b0}};
        case (bus.func)
            F_MFHI:  mf_s = hi_r;
            F_MFLO:  mf_s = lo_r;
            default: mf_s = {XLEN{1'b0}};
        endcase
    end

    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.mf_data = mf_s;
    assign bus.stall   = busy_r & bus.valid & is_hilo(bus.func);

    // Sequencer FSM with HI/LO, datapath and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            opa_r     <= {XLEN{1'b0}};
            acc_r     <= {XLEN{1'b0}};
            shr_r     <= {XLEN{1'b0}};
            rs_raw_r  <= {XLEN{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A flushed instruction is squashed, whatever its kind
                    if (bus.valid && !bus.flush && is_start(bus.func)) begin
                        opa_r     <= div_op_s ? mag(bus.rt_data, sgn_op_s) : mag(bus.rs_data, sgn_op_s);
                        shr_r     <= div_op_s ? mag(bus.rs_data, sgn_op_s) : mag(bus.rt_data, sgn_op_s);
                        acc_r     <= {XLEN{1'b0}};
                        rs_raw_r  <= bus.rs_data;
                        is_div_r  <= div_op_s;
                        neg_res_r <= sgn_op_s & (bus.rs_data[XLEN-1] ^ bus.rt_data[XLEN-1]);
                        neg_rem_r <= sgn_op_s & div_op_s & bus.rs_data[XLEN-1];
                        div0_r    <= div_op_s & (bus.rt_data == {XLEN{1'b0}});
                        cnt_r     <= ITER_C;
                        busy_r    <= 1'b1;
                        state_r   <= CALC;
                    end else if (bus.valid && !bus.flush && (bus.func == F_MTHI)) begin
                        hi_r <= bus.rs_data;
                    end else if (bus.valid && !bus.flush && (bus.func == F_MTLO)) begin
                        lo_r <= bus.rs_data;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        acc_r <= acc_next_s;
                        shr_r <= shr_next_s;
                        cnt_r <= cnt_r - ONE_C;
                        if (cnt_r == ONE_C) begin
                            state_r <= FIXUP;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                FIXUP: begin
                    if (bus.flush) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        hi_r    <= hi_res_s;
                        lo_r    <= lo_res_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer; expected HI/LO values
// come from plain 64-bit arithmetic on the operands.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus ();
    muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {hi, lo} from ordinary integer arithmetic
    function automatic logic [63:0] ref_hilo(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] q, m, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (f)
            6'h18: r = 64'(sa * sb);
            6'h19: r = {32'd0, a} * {32'd0, b};
            6'h1A: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else begin
                    q = 64'(sa / sb);
                    m = 64'(sa % sb);
                    r = {m[31:0], q[31:0]};
                end
            end
            6'h1B: r = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        exp = ref_hilo(f, a, b);
        bus.valid = 1'b1; bus.func = f; bus.rs_data = a; bus.rt_data = b;
        tick();
        bus.valid = 1'b0; bus.func = 6'h00;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, "_hi"}, bus.hi, exp[63:32]);
        check({tag, "_lo"}, bus.lo, exp[31:0]);
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] hold_hi, hold_lo;
        int          n, pulses;
        logic [5:0]  rf;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        bus.valid = 1'b0; bus.func = 6'h00; bus.rs_data = 32'd0; bus.rt_data = 32'd0;
        bus.flush = 1'b0;
        #3;
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        #19 rst_n = 1'b1;
        tick();

        // MTHI / MTLO write at the edge
        bus.valid = 1'b1; bus.func = 6'h11; bus.rs_data = 32'hA5A5_0001;
        tick();
        bus.func = 6'h13; bus.rs_data = 32'h5A5A_0002;
        tick();
        bus.valid = 1'b0; bus.func = 6'h00;
        check("mthi", bus.hi, 32'hA5A5_0001);
        check("mtlo", bus.lo, 32'h5A5A_0002);

        // Reset in the middle of MULT 7*9
        bus.valid = 1'b1; bus.func = 6'h18; bus.rs_data = 32'd7; bus.rt_data = 32'd9;
        tick();
        bus.valid = 1'b0; bus.func = 6'h00;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_hi", bus.hi, 32'd0);
        check("midreset_lo", bus.lo, 32'd0);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        check("midreset_no_done", 32'(pulses), 32'd0);
        check("midreset_lo_kept", bus.lo, 32'd0);

        run_op("mult_neg", 6'h18, 32'hFFFFFFFD, 32'd5);
        check("mult_neg_hi_const", bus.hi, 32'hFFFFFFFF);
        check("mult_neg_lo_const", bus.lo, 32'hFFFFFFF1);

        run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        bus.valid = 1'b1; bus.func = 6'h10;
        #1;
        check("mfhi_data", bus.mf_data, 32'hFFFFFFFE);
        check("mfhi_stall", 32'(bus.stall), 32'd0);
        bus.func = 6'h12;
        #1;
        check("mflo_data", bus.mf_data, 32'h00000001);
        bus.func = 6'h20;
        #1;
        check("mf_other_zero", bus.mf_data, 32'd0);
        bus.valid = 1'b0; bus.func = 6'h00;

        run_op("div_neg", 6'h1A, 32'hFFFFFFF9, 32'd2);
        check("div_neg_lo_const", bus.lo, 32'hFFFFFFFD);
        check("div_neg_hi_const", bus.hi, 32'hFFFFFFFF);
        run_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo_const", bus.lo, 32'h80000000);
        check("div_ovf_hi_const", bus.hi, 32'd0);
        run_op("divu_zero", 6'h1B, 32'd100, 32'd0);
        check("divu_zero_lo_const", bus.lo, 32'hFFFFFFFF);
        check("divu_zero_hi_const", bus.hi, 32'h00000064);
        run_op("div_neg_zero", 6'h1A, 32'hFFFFFF00, 32'd0);

        // MFLO issued 5 cycles after a MULT start is held until done
        exp = ref_hilo(6'h18, 32'h00012345, 32'h00000777);
        bus.valid = 1'b1; bus.func = 6'h18; bus.rs_data = 32'h00012345; bus.rt_data = 32'h00000777;
        tick();
        bus.valid = 1'b0; bus.func = 6'h00;
        repeat (4) tick();
        bus.valid = 1'b1; bus.func = 6'h12;
        #1;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            check("mflo_stall", 32'(bus.stall), 32'd1);
            tick();
            n++;
        end
        check("mflo_wait_done", 32'(bus.done), 32'd1);
        check("mflo_stall_released", 32'(bus.stall), 32'd0);
        check("mflo_new_value", bus.mf_data, exp[31:0]);
        bus.valid = 1'b0; bus.func = 6'h00;
        tick();

        // MTLO while busy is ignored; unrelated func does not stall
        exp = ref_hilo(6'h1B, 32'd1000, 32'd7);
        bus.valid = 1'b1; bus.func = 6'h1B; bus.rs_data = 32'd1000; bus.rt_data = 32'd7;
        tick();
        bus.func = 6'h13; bus.rs_data = 32'h00001234;
        repeat (3) begin
            tick();
            check("mtlo_busy_stall", 32'(bus.stall), 32'd1);
        end
        bus.func = 6'h20;
        #1;
        check("add_no_stall", 32'(bus.stall), 32'd0);
        bus.valid = 1'b0; bus.func = 6'h00;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("mtlo_ignored_lo", bus.lo, exp[31:0]);
        check("mtlo_ignored_hi", bus.hi, exp[63:32]);

        // Flush at cycle 10 of a DIV
        hold_hi = bus.hi; hold_lo = bus.lo;
        bus.valid = 1'b1; bus.func = 6'h1A; bus.rs_data = 32'hFFFFFC18; bus.rt_data = 32'd3;
        tick();
        bus.valid = 1'b0; bus.func = 6'h00;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        pulses = 0;
        repeat (40) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_hi_kept", bus.hi, hold_hi);
        check("flush_lo_kept", bus.lo, hold_lo);

        // Flush together with a start in IDLE suppresses it
        bus.valid = 1'b1; bus.func = 6'h19; bus.rs_data = 32'd3; bus.rt_data = 32'd3; bus.flush = 1'b1;
        tick();
        bus.valid = 1'b0; bus.func = 6'h00; bus.flush = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'd0);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            rf = 6'h18 + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 9));
            run_op($sformatf("rand%0d_f%0h", i, rf), rf, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
